// File: rtl/dmac_multi_ch_ctrl.sv
// DMA main controller: arbitrates NUM_CH peripheral requests onto one AHB master,
// with fixed or round-robin priority, request masking and a bus-grant timeout.
//
// state | meaning
// IDLE  | no channel latched, waiting for an eligible request
// REQ   | channel latched, requesting the bus, waiting for grant and config
// XFER  | channel transferring; paused while the grant is withdrawn
module dmac_multi_ch_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int ARB_MODE      = 0,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         DmacReq,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      Bus_Grant,
    input  logic                      C_config,
    input  logic                      irq,
    output logic                      Bus_Req,
    output logic                      hold,
    output logic [NUM_CH-1:0]         Channel_en,
    output logic [NUM_CH-1:0]         ReqAck,
    output logic                      Interrupt,
    output logic [$clog2(NUM_CH)-1:0] active_ch,
    output logic                      busy,
    output logic                      timeout_err
);
    localparam int CW = $clog2(NUM_CH);
    localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);
    localparam logic [CW:0]   NCH     = (CW + 1)'(NUM_CH);
    localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     sel, sel_nxt;
    logic [CW-1:0]     rr_ptr, rr_nxt;
    logic [TW-1:0]     wait_cnt, wait_nxt;
    logic [NUM_CH-1:0] eff;
    logic [CW-1:0]     winner;
    logic [CW:0]       idx;
    logic [CW-1:0]     rr_inc;
    logic              go;
    logic              to_hit;

    assign eff    = DmacReq & ch_mask;
    assign go     = Bus_Grant && C_config;
    assign to_hit = (GRANT_TIMEOUT != 0) && (wait_cnt == TO_LAST) && !go;
    assign rr_inc = (sel == CH_LAST) ? '0 : sel + CW'(1);

    // Round-robin scans downward in offset so the nearest bit at/after rr_ptr is kept.
    always_comb begin
        winner = '0;
        idx    = '0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < NUM_CH; i++)
                if (eff[i]) winner = CW'(i);
        end else begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr} + (CW + 1)'(k);
                if (idx >= NCH) idx = idx - NCH;
                if (eff[idx[CW-1:0]]) winner = idx[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            rr_ptr   <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr_ptr   <= rr_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        wait_nxt  = wait_cnt;
        case (state)
            IDLE: begin
                if (|eff) begin
                    state_nxt = REQ;
                    sel_nxt   = winner;
                    wait_nxt  = '0;
                end
            end
            REQ: begin
                if (go) begin
                    state_nxt = XFER;
                end else if (to_hit) begin
                    state_nxt = IDLE;
                    rr_nxt    = rr_inc;
                end else begin
                    wait_nxt = wait_cnt + TW'(1);
                end
            end
            XFER: begin
                if (irq) begin
                    state_nxt = IDLE;
                    rr_nxt    = rr_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Bus_Req     = 1'b0;
        hold        = 1'b0;
        busy        = 1'b0;
        active_ch   = '0;
        Channel_en  = '0;
        ReqAck      = '0;
        Interrupt   = 1'b0;
        timeout_err = 1'b0;
        if (state != IDLE) begin
            Bus_Req   = 1'b1;
            hold      = 1'b1;
            busy      = 1'b1;
            active_ch = sel;
        end
        case (state)
            REQ: begin
                if (go) ReqAck[sel] = 1'b1;
                timeout_err = to_hit;
            end
            XFER: begin
                // irq wins over a simultaneous grant drop: channel is shut either way
                if (irq) Interrupt = 1'b1;
                else     Channel_en[sel] = Bus_Grant;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dmac_multi_ch_ctrl.sv
// Bench for dmac_multi_ch_ctrl: a fixed-priority and a round-robin instance share
// stimulus; served channels are checked against a scoreboard of expected ReqAcks.
module tb_dmac_multi_ch_ctrl;
    localparam int NCH = 4;
    localparam int GT  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] DmacReq, ch_mask;
    logic           Bus_Grant, C_config, irq;

    logic           f_bus_req, f_hold, f_intr, f_busy, f_to;
    logic [NCH-1:0] f_ch_en, f_ack;
    logic [1:0]     f_act;
    logic           r_bus_req, r_hold, r_intr, r_busy, r_to;
    logic [NCH-1:0] r_ch_en, r_ack;
    logic [1:0]     r_act;
    logic [14:0]    f_all, r_all;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] q_fix[$];
    logic [1:0] q_rr[$];

    assign f_all = {f_bus_req, f_hold, f_busy, f_intr, f_to, f_ch_en, f_ack, f_act};
    assign r_all = {r_bus_req, r_hold, r_busy, r_intr, r_to, r_ch_en, r_ack, r_act};

    always #5 clk = ~clk;

    dmac_multi_ch_ctrl #(.NUM_CH(NCH), .ARB_MODE(0), .GRANT_TIMEOUT(GT)) u_fix (
        .clk(clk), .rst(rst), .DmacReq(DmacReq), .ch_mask(ch_mask),
        .Bus_Grant(Bus_Grant), .C_config(C_config), .irq(irq),
        .Bus_Req(f_bus_req), .hold(f_hold), .Channel_en(f_ch_en), .ReqAck(f_ack),
        .Interrupt(f_intr), .active_ch(f_act), .busy(f_busy), .timeout_err(f_to)
    );

    dmac_multi_ch_ctrl #(.NUM_CH(NCH), .ARB_MODE(1), .GRANT_TIMEOUT(GT)) u_rr (
        .clk(clk), .rst(rst), .DmacReq(DmacReq), .ch_mask(ch_mask),
        .Bus_Grant(Bus_Grant), .C_config(C_config), .irq(irq),
        .Bus_Req(r_bus_req), .hold(r_hold), .Channel_en(r_ch_en), .ReqAck(r_ack),
        .Interrupt(r_intr), .active_ch(r_act), .busy(r_busy), .timeout_err(r_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every ReqAck pulse must match the next expected channel for that instance.
    always @(negedge clk) begin
        if (!rst && f_ack != '0) begin
            if (q_fix.size() == 0) check("fix_ack_unexpected", 32'(f_ack), 32'd0);
            else                   check("fix_ack", 32'(f_ack), 32'(1) << q_fix.pop_front());
        end
        if (!rst && r_ack != '0) begin
            if (q_rr.size() == 0) check("rr_ack_unexpected", 32'(r_ack), 32'd0);
            else                  check("rr_ack", 32'(r_ack), 32'(1) << q_rr.pop_front());
        end
    end

    // Starts in an IDLE cycle, returns in the IDLE cycle after irq.
    task automatic run_xfer(input logic [3:0] req, input bit keep_req, input int n_wait,
                            input int n_xfer, input int n_gap, input bit drop_at_irq,
                            input logic [1:0] e_fix, input logic [1:0] e_rr);
        DmacReq   = req;
        Bus_Grant = 1'b0;
        C_config  = 1'b0;
        irq       = 1'b0;
        q_fix.push_back(e_fix);
        q_rr.push_back(e_rr);
        @(negedge clk);
        check("idle_outputs", 32'({f_busy, r_busy, f_bus_req, r_bus_req, f_intr, r_intr}), 0);
        step();
        if (!keep_req) DmacReq = '0;
        for (int i = 0; i < n_wait; i++) begin
            @(negedge clk);
            check("req_bus_hold", 32'({f_bus_req, r_bus_req, f_hold, r_hold}), 32'hf);
            check("req_active_ch", 32'({f_act, r_act}), 32'({e_fix, e_rr}));
            check("req_no_ack_en", 32'({f_ack, r_ack, f_ch_en, r_ch_en}), 0);
            step();
        end
        Bus_Grant = 1'b1;
        C_config  = 1'b1;
        @(negedge clk);
        check("grant_cycle_no_en", 32'({f_ch_en, r_ch_en}), 0);
        step();
        C_config = 1'b0;
        for (int i = 0; i < n_xfer; i++) begin
            Bus_Grant = 1'b1;
            @(negedge clk);
            check("xfer_ch_en", 32'({f_ch_en, r_ch_en}), 32'({4'b0001 << e_fix, 4'b0001 << e_rr}));
            check("xfer_quiet", 32'({f_intr, r_intr, f_to, r_to}), 0);
            step();
            if (i == 0) begin
                for (int g = 0; g < n_gap; g++) begin
                    Bus_Grant = 1'b0;
                    @(negedge clk);
                    check("gap_ch_en", 32'({f_ch_en, r_ch_en}), 0);
                    check("gap_bus_req", 32'({f_bus_req, r_bus_req, f_busy, r_busy}), 32'hf);
                    step();
                end
            end
        end
        Bus_Grant = !drop_at_irq;
        irq       = 1'b1;
        @(negedge clk);
        check("irq_intr", 32'({f_intr, r_intr}), 32'h3);
        check("irq_ch_en", 32'({f_ch_en, r_ch_en}), 0);
        step();
        irq       = 1'b0;
        Bus_Grant = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        DmacReq   = '1;
        ch_mask   = '1;
        Bus_Grant = 1'b1;
        C_config  = 1'b1;
        irq       = 1'b1;
        step();
        step();
        @(negedge clk);
        check("reset_outputs", 32'({f_all, r_all}), 0);
        rst       = 1'b0;
        DmacReq   = '0;
        Bus_Grant = 1'b0;
        C_config  = 1'b0;
        irq       = 1'b0;
        step();

        // Held 1111: round-robin rotates, fixed always picks the top channel.
        run_xfer(4'b1111, 1'b1, 1, 5, 0, 1'b0, 2'd3, 2'd0);
        run_xfer(4'b1111, 1'b1, 1, 5, 0, 1'b0, 2'd3, 2'd1);
        run_xfer(4'b1111, 1'b1, 1, 5, 0, 1'b0, 2'd3, 2'd2);
        run_xfer(4'b1111, 1'b1, 1, 5, 0, 1'b0, 2'd3, 2'd3);
        run_xfer(4'b1111, 1'b1, 1, 5, 0, 1'b0, 2'd3, 2'd0);

        // 0101 with grant after three REQ cycles; request dropped after latching.
        run_xfer(4'b0101, 1'b0, 3, 3, 0, 1'b0, 2'd2, 2'd2);

        // Grant withdrawn for four cycles, then irq together with a grant drop.
        run_xfer(4'b0010, 1'b0, 1, 3, 4, 1'b1, 2'd1, 2'd1);

        // Grant timeout on channel 3 with config valid but no grant.
        DmacReq  = 4'b1000;
        C_config = 1'b1;
        @(negedge clk);
        check("to_idle", 32'({f_busy, r_busy}), 0);
        step();
        DmacReq = '0;
        for (int i = 1; i <= GT; i++) begin
            @(negedge clk);
            check("to_pulse", 32'({f_to, r_to}), (i == GT) ? 32'h3 : 32'h0);
            check("to_bus_req", 32'({f_bus_req, r_bus_req}), 32'h3);
            step();
        end
        @(negedge clk);
        check("to_after", 32'({f_bus_req, r_bus_req, f_busy, r_busy, f_to, r_to}), 0);
        step();
        C_config = 1'b0;
        // rr_ptr wrapped to 0, so round-robin now picks 1 out of 0110.
        run_xfer(4'b0110, 1'b0, 0, 2, 0, 1'b0, 2'd2, 2'd1);

        // Masked channel 0 must be ignored until unmasked.
        ch_mask = 4'b1110;
        DmacReq = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("masked_idle", 32'({f_bus_req, r_bus_req, f_busy, r_busy}), 0);
            step();
        end
        ch_mask = 4'b1111;
        run_xfer(4'b0001, 1'b0, 2, 2, 0, 1'b0, 2'd0, 2'd0);

        // Reset in the middle of a channel-3 transfer.
        DmacReq = 4'b1000;
        q_fix.push_back(2'd3);
        q_rr.push_back(2'd3);
        @(negedge clk);
        check("rst_pre_idle", 32'({f_busy, r_busy}), 0);
        step();
        DmacReq   = '0;
        Bus_Grant = 1'b1;
        C_config  = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("rst_pre_xfer_en", 32'({f_ch_en, r_ch_en}), 32'h88);
        check("rst_pre_act", 32'({f_act, r_act}), 32'hf);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_xfer", 32'({f_all, r_all}), 0);
        step();
        Bus_Grant = 1'b0;
        C_config  = 1'b0;
        // rr_ptr back at 0: round-robin picks 0 out of 0011, fixed picks 1.
        run_xfer(4'b0011, 1'b0, 1, 2, 0, 1'b0, 2'd1, 2'd0);

        @(negedge clk);
        check("final_idle", 32'({f_all, r_all}), 0);
        check("sb_fix_empty", 32'(q_fix.size()), 0);
        check("sb_rr_empty", 32'(q_rr.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
